// File: rtl/fifo_pkg.sv
// Shared FIFO types and default sizing constants.
package fifo_pkg;

  typedef enum logic {MODE_STD, MODE_FWFT} fifo_mode_e;

  localparam int FIFO_DATA_W_DEF = 8;
  localparam int FIFO_DEPTH_DEF  = 16;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W simple dual-port storage: synchronous write, asynchronous read.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with thresholds, occupancy count, sticky
// error flags and a selectable registered or first-word-fall-through read.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int         DATA_W    = FIFO_DATA_W_DEF,
  parameter int         DEPTH     = FIFO_DEPTH_DEF,
  parameter int         AF_THRESH = DEPTH - 2,
  parameter int         AE_THRESH = 2,
  parameter fifo_mode_e MODE      = MODE_STD,
  localparam int        CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              push,
  output logic              full,
  output logic              almost_full,
  output logic [DATA_W-1:0] data_out,
  input  logic              pop,
  output logic              empty,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] mem_rdata;
  logic              wr_en, rd_en;

  // Explicit wrap compare keeps non-power-of-two depths correct.
  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full         = (count_q == CNT_W'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_W'(AF_THRESH));
  assign almost_empty = (count_q <= CNT_W'(AE_THRESH));
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (push && full);
    unf_d    = unf_q | (pop && empty);
    dout_d   = dout_q;
    if (wr_en) wr_ptr_d = ptr_next(wr_ptr_q);
    if (rd_en) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
      dout_d   = mem_rdata;
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dout_q   <= dout_d;
    end
  end

  // Reset must also block the array write so a push during reset is lost.
  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en && !rst),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  assign data_out = (MODE == MODE_FWFT) ? mem_rdata : dout_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench: three FIFO variants share one stimulus stream and are
// compared against queue-based reference models.
module tb_sync_fifo_param;
  import fifo_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0, push = 1'b0, pop = 1'b0;
  logic [7:0] din = 8'h00;

  logic [7:0] dout    [N];
  logic [2:0] cnt_w   [N];
  logic       full_w  [N];
  logic       af_w    [N];
  logic       empty_w [N];
  logic       ae_w    [N];
  logic       ovf_w   [N];
  logic       unf_w   [N];

  sync_fifo_param #(.DATA_W(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .MODE(MODE_STD)) u0 (
    .clk(clk), .rst(rst), .data_in(din), .push(push), .full(full_w[0]),
    .almost_full(af_w[0]), .data_out(dout[0]), .pop(pop), .empty(empty_w[0]),
    .almost_empty(ae_w[0]), .count(cnt_w[0]), .overflow(ovf_w[0]), .underflow(unf_w[0]));

  sync_fifo_param #(.DATA_W(8), .DEPTH(5), .AF_THRESH(3), .AE_THRESH(1), .MODE(MODE_STD)) u1 (
    .clk(clk), .rst(rst), .data_in(din), .push(push), .full(full_w[1]),
    .almost_full(af_w[1]), .data_out(dout[1]), .pop(pop), .empty(empty_w[1]),
    .almost_empty(ae_w[1]), .count(cnt_w[1]), .overflow(ovf_w[1]), .underflow(unf_w[1]));

  sync_fifo_param #(.DATA_W(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .MODE(MODE_FWFT)) u2 (
    .clk(clk), .rst(rst), .data_in(din), .push(push), .full(full_w[2]),
    .almost_full(af_w[2]), .data_out(dout[2]), .pop(pop), .empty(empty_w[2]),
    .almost_empty(ae_w[2]), .count(cnt_w[2]), .overflow(ovf_w[2]), .underflow(unf_w[2]));

  function automatic int dep(input int i);
    return (i == 1) ? 5 : 4;
  endfunction

  function automatic bit is_fwft(input int i);
    return (i == 2);
  endfunction

  // Reference model: queue contents, sticky flags, registered STD output.
  logic [7:0] mq    [N][$];
  logic [7:0] exp_q [N][$];
  bit         m_ovf [N];
  bit         m_unf [N];
  logic [7:0] m_std [N];

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s u%0d: got %0h expected %0h (t=%0t)", nm, i, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs and advance every model to its post-edge state.
  task automatic step(input bit r, input bit p, input bit o, input logic [7:0] d);
    @(negedge clk);
    rst = r; push = p; pop = o; din = d;
    for (int i = 0; i < N; i++) begin
      int sz;
      sz = mq[i].size();
      if (r) begin
        mq[i].delete();
        m_ovf[i] = 1'b0;
        m_unf[i] = 1'b0;
        m_std[i] = 8'h00;
      end else begin
        if (p && sz == dep(i)) m_ovf[i] = 1'b1;
        if (o && sz == 0)      m_unf[i] = 1'b1;
        if (o && sz > 0)       m_std[i] = mq[i].pop_front();
        if (p && sz < dep(i))  mq[i].push_back(d);
      end
      if (!is_fwft(i)) exp_q[i].push_back(m_std[i]);
    end
    armed = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (armed) begin
      for (int i = 0; i < N; i++) begin
        int sz;
        sz = mq[i].size();
        chk("count", i, 32'(cnt_w[i]), sz);
        chk("empty", i, 32'(empty_w[i]), 32'(sz == 0));
        chk("full", i, 32'(full_w[i]), 32'(sz == dep(i)));
        chk("almost_full", i, 32'(af_w[i]), 32'(sz >= 3));
        chk("almost_empty", i, 32'(ae_w[i]), 32'(sz <= 1));
        chk("overflow", i, 32'(ovf_w[i]), 32'(m_ovf[i]));
        chk("underflow", i, 32'(unf_w[i]), 32'(m_unf[i]));
        if (is_fwft(i)) begin
          if (sz > 0) chk("fwft_data", i, 32'(dout[i]), 32'(mq[i][0]));
        end else if (exp_q[i].size() > 0) begin
          chk("std_data", i, 32'(dout[i]), 32'(exp_q[i].pop_front()));
        end
      end
    end
  end

  initial begin
    int pw, pr;
    // Reset with push and pop held
    step(1, 1, 1, 8'hEE);
    step(0, 0, 0, 8'h00);
    // Fill to full, then one overflowing push
    for (int k = 0; k < 5; k++) step(0, 1, 0, 8'hA1 + 8'(k));
    // Drain, then one underflowing pop
    for (int k = 0; k < 5; k++) step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);
    // Preload two words, then simultaneous push+pop across several wraps
    step(0, 1, 0, 8'h10);
    step(0, 1, 0, 8'h11);
    for (int k = 0; k < 10; k++) step(0, 1, 1, 8'h12 + 8'(k));
    step(0, 0, 0, 8'h00);
    // Drain, then fall-through of a single word into an empty FIFO
    step(0, 0, 1, 8'h00);
    step(0, 0, 1, 8'h00);
    step(0, 1, 0, 8'h55);
    step(0, 0, 0, 8'h00);
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);
    // Push+pop while empty: write taken, read rejected
    step(0, 1, 1, 8'h66);
    step(0, 0, 1, 8'h00);
    // Reset outranks push and pop in the same cycle
    for (int k = 0; k < 3; k++) step(0, 1, 0, 8'h30 + 8'(k));
    step(1, 1, 1, 8'h77);
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);
    // Randomised phases: balanced, push-heavy, pop-heavy
    for (int ph = 0; ph < 3; ph++) begin
      pw = (ph == 1) ? 8 : ((ph == 2) ? 3 : 6);
      pr = (ph == 2) ? 8 : ((ph == 1) ? 3 : 6);
      for (int k = 0; k < 200; k++) begin
        step(($urandom_range(0, 59) == 0),
             ($urandom_range(0, 9) < pw),
             ($urandom_range(0, 9) < pr),
             8'($urandom));
      end
    end
    step(0, 0, 0, 8'h00);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
